lp_core_monitor: RTL and testbench

//  Scoreboard beside the PHOLD event scheduler. Records which logical process (LP)
//  and timestamp each core is working on, as events are dispatched to it.

---
 rtl/lp_core_monitor_pkg.sv | 32 +++
 rtl/lp_core_monitor_if.sv | 12 +
 rtl/lp_core_monitor_min_tree.sv | 24 ++
 rtl/lp_core_monitor.sv | 76 +++++++
 tb/tb_lp_core_monitor.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/lp_core_monitor_pkg.sv
// Shared configuration, types and event-message field accessors for the LP core monitor.
package lp_core_monitor_pkg;

    localparam int unsigned NUM_CORE = 4;
    localparam int unsigned NUM_LP   = 8;
    localparam int unsigned TIME_WID = 16;
    localparam int unsigned MSG_WID  = 32;
    localparam int unsigned LPW      = $clog2(NUM_LP);
    localparam int unsigned CIDW     = $clog2(NUM_CORE);
    localparam int unsigned LP_OFS   = TIME_WID;

    typedef logic [MSG_WID-1:0]  msg_t;
    typedef logic [TIME_WID-1:0] time_t;
    typedef logic [LPW-1:0]      lp_t;
    typedef logic [CIDW-1:0]     core_id_t;

    typedef struct packed {
        logic     sent_msg_vld;
        logic     rcv_msg_vld;
        core_id_t core_id;
        msg_t     msg;
    } sched_bus_t;

    function automatic lp_t msg_lp(input msg_t m);
        return m[LP_OFS +: LPW];
    endfunction

    function automatic time_t msg_time(input msg_t m);
        return m[TIME_WID-1:0];
    endfunction

endpackage

// File: rtl/lp_core_monitor_if.sv
// Scheduler-to-monitor event bus: dispatched/received message with its core index.
interface lp_core_monitor_if;

    lp_core_monitor_pkg::msg_t     msg;
    logic                          sent_msg_vld;
    logic                          rcv_msg_vld;
    lp_core_monitor_pkg::core_id_t core_id;

    modport master (output msg, output sent_msg_vld, output rcv_msg_vld, output core_id);
    modport slave  (input  msg, input  sent_msg_vld, input  rcv_msg_vld, input  core_id);

endinterface

// File: rtl/lp_core_monitor_min_tree.sv
// Combinational unsigned minimum over N values, each qualified by its own valid bit.
module lp_core_monitor_min_tree #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 16
) (
    input  logic [N-1:0] vld,
    input  logic [W-1:0] val [N],
    output logic [W-1:0] min_c,
    output logic         min_vld_c
);

    // Running reduction; result stays 0 when nothing is valid.
    always_comb begin
        min_c     = '0;
        min_vld_c = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (vld[i] && (!min_vld_c || (val[i] < min_c))) begin
                min_c     = val[i];
                min_vld_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lp_core_monitor.sv
// Tracks the LP/timestamp each core is processing, stalls out-of-order work on a shared LP,
// and reports the minimum in-flight timestamp for GVT.
module lp_core_monitor
    import lp_core_monitor_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    lp_core_monitor_if.slave        bus,
    input  logic [NUM_CORE-1:0]     core_active,
    input  logic [4*NUM_CORE-1:0]   core_hist_cnt,
    output logic [NUM_CORE-1:0]     stall,
    output time_t                   min_time,
    output logic                    min_time_vld
);

    lp_t                 core_LP_id [NUM_CORE];
    time_t               core_time  [NUM_CORE];
    logic [NUM_CORE-1:0] disp;
    logic [NUM_CORE-1:0] tracked;
    sched_bus_t          req;

    assign req = '{sent_msg_vld: bus.sent_msg_vld, rcv_msg_vld: bus.rcv_msg_vld,
                   core_id: bus.core_id, msg: bus.msg};

    // Received events and history counts do not affect tracking.
    logic unused_ok;
    assign unused_ok = ^{req.rcv_msg_vld, core_hist_cnt, req.msg};

    // Per-core entry capture; disp bridges the cycle before the core raises core_active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CORE); i++) begin
                core_LP_id[i] <= '0;
                core_time[i]  <= '0;
            end
            disp <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CORE); i++) begin
                disp[i] <= req.sent_msg_vld && (req.core_id == CIDW'(i));
            end
            if (req.sent_msg_vld) begin
                core_LP_id[req.core_id] <= msg_lp(req.msg);
                core_time[req.core_id]  <= msg_time(req.msg);
            end
        end
    end

    assign tracked = core_active | disp;

    // A core stalls if another tracked core on the same LP holds an older event (ties: lower index wins).
    for (genvar gi = 0; gi < int'(NUM_CORE); gi++) begin : g_stall
        logic older_c;
        always_comb begin
            older_c = 1'b0;
            for (int j = 0; j < int'(NUM_CORE); j++) begin
                if ((j != gi) && tracked[j] && (core_LP_id[j] == core_LP_id[gi]) &&
                    ((core_time[j] < core_time[gi]) ||
                     ((core_time[j] == core_time[gi]) && (j < gi)))) begin
                    older_c = 1'b1;
                end
            end
        end
        assign stall[gi] = tracked[gi] & older_c;
    end

    lp_core_monitor_min_tree #(
        .N (NUM_CORE),
        .W (TIME_WID)
    ) u_min_tree (
        .vld       (tracked),
        .val       (core_time),
        .min_c     (min_time),
        .min_vld_c (min_time_vld)
    );

endmodule

// File: tb/tb_lp_core_monitor.sv
// Directed bench for lp_core_monitor: stall ordering, minimum timestamp, dispatch pulse, reset.
module tb_lp_core_monitor;
    import lp_core_monitor_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic [NUM_CORE-1:0]   core_active;
    logic [4*NUM_CORE-1:0] core_hist_cnt;
    logic [NUM_CORE-1:0]   stall;
    time_t                 min_time;
    logic                  min_time_vld;

    int nvec;
    int nerr;

    lp_core_monitor_if bus ();

    lp_core_monitor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .core_active   (core_active),
        .core_hist_cnt (core_hist_cnt),
        .stall         (stall),
        .min_time      (min_time),
        .min_time_vld  (min_time_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic msg_t mk_msg(input int lp, input int t);
        msg_t m;
        m = '0;
        m[TIME_WID-1:0]    = TIME_WID'(t);
        m[TIME_WID +: LPW] = LPW'(lp);
        m[TIME_WID+3]      = 1'b1;
        return m;
    endfunction

    // Dispatch for one clock edge; returns 1 time unit after the following negedge.
    task automatic dispatch(input int core, input int lp, input int t);
        @(negedge clk);
        bus.msg          = mk_msg(lp, t);
        bus.core_id      = CIDW'(core);
        bus.sent_msg_vld = 1'b1;
        @(negedge clk);
        bus.sent_msg_vld = 1'b0;
        bus.msg          = '0;
        #1;
    endtask

    task automatic check_out(input string name, input logic [NUM_CORE-1:0] exp_stall,
                             input int exp_min, input logic exp_vld);
        nvec++;
        if (stall !== exp_stall) begin
            nerr++;
            $display("FAIL %s stall: got %b expected %b", name, stall, exp_stall);
        end
        nvec++;
        if (min_time !== TIME_WID'(exp_min)) begin
            nerr++;
            $display("FAIL %s min_time: got %0d expected %0d", name, min_time, exp_min);
        end
        nvec++;
        if (min_time_vld !== exp_vld) begin
            nerr++;
            $display("FAIL %s min_time_vld: got %b expected %b", name, min_time_vld, exp_vld);
        end
    endtask

    task automatic test_reset();
        rst_n            = 1'b0;
        core_active      = '0;
        core_hist_cnt    = '0;
        bus.msg          = '0;
        bus.core_id      = '0;
        bus.sent_msg_vld = 1'b0;
        bus.rcv_msg_vld  = 1'b0;
        #12;
        check_out("reset", 4'b0000, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_out("post_reset", 4'b0000, 0, 1'b0);
    endtask

    task automatic test_dispatch();
        core_active   = 4'b0010;
        core_hist_cnt = 16'hA5C3;
        dispatch(1, 3, 100);
        check_out("dispatch_core1", 4'b0000, 100, 1'b1);
    endtask

    task automatic test_older_same_lp();
        core_active = 4'b0110;
        dispatch(2, 3, 50);
        check_out("older_same_lp", 4'b0010, 50, 1'b1);
        @(negedge clk);
        core_active = 4'b0010;
        #1;
        check_out("drop_core2", 4'b0000, 100, 1'b1);
    endtask

    task automatic test_equal_times();
        core_active = 4'b1001;
        dispatch(0, 5, 70);
        dispatch(3, 5, 70);
        check_out("equal_times", 4'b1000, 70, 1'b1);
    endtask

    task automatic test_diff_lp();
        core_active = 4'b0011;
        dispatch(0, 1, 10);
        dispatch(1, 2, 5);
        check_out("diff_lp", 4'b0000, 5, 1'b1);
    endtask

    task automatic test_rcv_only();
        @(negedge clk);
        bus.msg         = mk_msg(3, 1);
        bus.core_id     = '0;
        bus.rcv_msg_vld = 1'b1;
        @(negedge clk);
        bus.rcv_msg_vld = 1'b0;
        bus.msg         = '0;
        #1;
        check_out("rcv_only", 4'b0000, 5, 1'b1);
        @(negedge clk);
        #1;
        check_out("rcv_only_later", 4'b0000, 5, 1'b1);
    endtask

    task automatic test_disp_pulse();
        core_active = 4'b0000;
        #1;
        check_out("idle", 4'b0000, 0, 1'b0);
        dispatch(2, 4, 3);
        check_out("disp_pulse", 4'b0000, 3, 1'b1);
        @(negedge clk);
        #1;
        check_out("disp_expired", 4'b0000, 0, 1'b0);
    endtask

    task automatic test_redispatch();
        core_active = 4'b0100;
        dispatch(2, 4, 30);
        dispatch(2, 4, 20);
        check_out("redispatch", 4'b0000, 20, 1'b1);
    endtask

    task automatic test_both_valid();
        core_active     = 4'b0101;
        bus.rcv_msg_vld = 1'b1;
        dispatch(2, 1, 4);
        bus.rcv_msg_vld = 1'b0;
        check_out("both_valid", 4'b0001, 4, 1'b1);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        #2;
        rst_n       = 1'b0;
        core_active = 4'b0000;
        #1;
        check_out("mid_reset", 4'b0000, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        core_active = 4'b0001;
        #1;
        check_out("after_mid_reset", 4'b0000, 0, 1'b1);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_dispatch();
        test_older_same_lp();
        test_equal_times();
        test_diff_lp();
        test_rcv_only();
        test_disp_pulse();
        test_redispatch();
        test_both_valid();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
